systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_seq_ctrl_if.sv | 25 ++
 rtl/seq_counter.sv | 25 ++
 rtl/systolic_seq_ctrl.sv | 118 +++++++++++
 tb/tb_systolic_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared encodings for the systolic array sequencer: FSM states, tile mode codes
// and the skewed feed length.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    localparam logic [1:0] C3_HOLD    = 2'b00;
    localparam logic [1:0] C3_COMPUTE = 2'b01;
    localparam logic [1:0] C3_SHIFT   = 2'b10;

    // Operands plus the diagonal skew needed to reach the far corner of the array.
    function automatic int feed_len(input int k_depth, input int units_x, input int units_y);
        return k_depth + units_x + units_y - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and the tile array, ROMs and RAMs.
interface systolic_seq_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              in_ready;
    logic              c1;
    logic              c2;
    logic [1:0]        c3;
    logic [ADDR_W-1:0] address_read;
    logic [ADDR_W-1:0] address_write;
    logic              data_valid_out;
    logic              busy;
    logic              done;

    modport master (
        input  start, in_ready,
        output c1, c2, c3, address_read, address_write, data_valid_out, busy, done
    );

    modport slave (
        output start, in_ready,
        input  c1, c2, c3, address_read, address_write, data_valid_out, busy, done
    );
endinterface

// File: rtl/seq_counter.sv
// Loadable up-counter that wraps to zero after LIMIT-1 and flags its terminal count.
module seq_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             last
);
    assign last = (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= last ? '0 : count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Start/busy/done sequencer: clear accumulators, stream skewed operands, drain,
// then unload result rows. Every output is a register updated with the state.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int UNITS_X = 2,
    parameter int UNITS_Y = 2,
    parameter int K_DEPTH = 4,
    parameter int ADDR_W  = 8
) (
    input  logic               CLK,
    input  logic               reset,
    systolic_seq_ctrl_if.master bus
);
    localparam int FEED_LEN = feed_len(K_DEPTH, UNITS_X, UNITS_Y);

    generate
        if (FEED_LEN >= (1 << ADDR_W) || UNITS_Y >= (1 << ADDR_W)) begin : g_addr_too_narrow
            $error("systolic_seq_ctrl: ADDR_W too narrow for FEED_LEN or UNITS_Y");
        end
    endgenerate

    state_t            state_reg;
    logic              feed_accept;
    logic [ADDR_W-1:0] feed_count;
    logic              feed_last;
    logic [ADDR_W-1:0] unload_count;
    logic              unload_last;

    assign feed_accept = (state_reg == ST_FEED) && bus.in_ready;

    seq_counter #(.WIDTH(ADDR_W), .LIMIT(FEED_LEN)) feed_counter (
        .clk        (CLK),
        .reset      (reset),
        .load       (state_reg == ST_CLEAR),
        .load_value ('0),
        .en         (feed_accept),
        .count      (feed_count),
        .last       (feed_last)
    );

    seq_counter #(.WIDTH(ADDR_W), .LIMIT(UNITS_Y)) unload_counter (
        .clk        (CLK),
        .reset      (reset),
        .load       (state_reg == ST_DRAIN),
        .load_value ('0),
        .en         (state_reg == ST_UNLOAD),
        .count      (unload_count),
        .last       (unload_last)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            bus.c1             <= 1'b0;
            bus.c2             <= 1'b0;
            bus.c3             <= C3_HOLD;
            bus.address_read   <= '0;
            bus.address_write  <= '0;
            bus.data_valid_out <= 1'b0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
        end else begin
            // Pulsed outputs default low; c2 trails each accepted address by the ROM latency.
            bus.c1             <= 1'b0;
            bus.c2             <= feed_accept;
            bus.data_valid_out <= 1'b0;
            bus.done           <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    bus.c3 <= C3_HOLD;
                    if (bus.start) begin
                        state_reg <= ST_CLEAR;
                        bus.c1    <= 1'b1;
                        bus.busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_reg        <= ST_FEED;
                    bus.c3           <= C3_COMPUTE;
                    bus.address_read <= '0;
                end
                ST_FEED: begin
                    if (feed_accept) begin
                        if (feed_last) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            bus.address_read <= feed_count + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    state_reg          <= ST_UNLOAD;
                    bus.c3             <= C3_SHIFT;
                    bus.data_valid_out <= 1'b1;
                    bus.address_write  <= '0;
                end
                ST_UNLOAD: begin
                    if (unload_last) begin
                        state_reg <= ST_DONE;
                        bus.c3    <= C3_HOLD;
                        bus.done  <= 1'b1;
                    end else begin
                        bus.data_valid_out <= 1'b1;
                        bus.address_write  <= unload_count + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    bus.busy  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench: two sequencers (default and 4x4/K=8), random stalls and start pokes.
module tb_systolic_seq_ctrl;

    localparam int K_C1 = 1, K_C2 = 2, K_WR = 3, K_DONE = 4;
    localparam int FL[2] = '{6, 14};
    localparam int UY[2] = '{2, 4};

    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic rst[2];
    logic start_s[2];
    logic ir_s[2];

    logic       c1_s[2], c2_s[2], dvo_s[2], busy_s[2], done_s[2];
    logic [1:0] c3_s[2];
    logic [7:0] ar_s[2], aw_s[2];

    ev_t exp_q[2][$];
    int  prev_ar[2];

    systolic_seq_ctrl_if #(.ADDR_W(8)) bus0 ();
    systolic_seq_ctrl_if #(.ADDR_W(8)) bus1 ();

    assign bus0.start    = start_s[0];
    assign bus0.in_ready = ir_s[0];
    assign bus1.start    = start_s[1];
    assign bus1.in_ready = ir_s[1];

    assign c1_s[0] = bus0.c1;  assign c2_s[0] = bus0.c2;  assign c3_s[0] = bus0.c3;
    assign ar_s[0] = bus0.address_read;  assign aw_s[0] = bus0.address_write;
    assign dvo_s[0] = bus0.data_valid_out;  assign busy_s[0] = bus0.busy;  assign done_s[0] = bus0.done;
    assign c1_s[1] = bus1.c1;  assign c2_s[1] = bus1.c2;  assign c3_s[1] = bus1.c3;
    assign ar_s[1] = bus1.address_read;  assign aw_s[1] = bus1.address_write;
    assign dvo_s[1] = bus1.data_valid_out;  assign busy_s[1] = bus1.busy;  assign done_s[1] = bus1.done;

    systolic_seq_ctrl #(.UNITS_X(2), .UNITS_Y(2), .K_DEPTH(4), .ADDR_W(8)) dut0 (
        .CLK(clk), .reset(rst[0]), .bus(bus0)
    );
    systolic_seq_ctrl #(.UNITS_X(4), .UNITS_Y(4), .K_DEPTH(8), .ADDR_W(8)) dut1 (
        .CLK(clk), .reset(rst[1]), .bus(bus1)
    );

    // Reference: from the start cycle and the in_ready pattern, list every pulse the
    // array should see. Returns the cycle of the done pulse.
    task automatic model(input int w, input int t0, input bit ir[256], output int done_c);
        int t, k;
        exp_q[w].push_back('{t0 + 1, K_C1, 1});
        t = t0 + 2;
        k = 0;
        while (k < FL[w]) begin
            if (ir[t - t0 - 1]) begin
                exp_q[w].push_back('{t + 1, K_C2, k});
                k++;
            end
            t++;
        end
        for (int i = 0; i < UY[w]; i++) exp_q[w].push_back('{t + 1 + i, K_WR, i});
        done_c = t + 1 + UY[w];
        exp_q[w].push_back('{done_c, K_DONE, 1});
    endtask

    task automatic mon(input int w);
        int  nh, kind, act, exp_c3;
        ev_t e;
        while (exp_q[w].size() > 0 && exp_q[w][0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missed_event inst=%0d kind=%0d expected_cyc=%0d actual=absent", w,
                     exp_q[w][0].kind, exp_q[w][0].cyc);
            void'(exp_q[w].pop_front());
        end
        nh = int'(c1_s[w]) + int'(c2_s[w]) + int'(dvo_s[w]) + int'(done_s[w]);
        if (nh > 0) begin
            checks++;
            if (nh > 1) begin
                errors++;
                $display("FAIL overlap inst=%0d cyc=%0d c1=%b c2=%b dvo=%b done=%b required<=1 high",
                         w, cyc, c1_s[w], c2_s[w], dvo_s[w], done_s[w]);
            end
            kind = c1_s[w] ? K_C1 : c2_s[w] ? K_C2 : dvo_s[w] ? K_WR : K_DONE;
            checks++;
            if (exp_q[w].size() == 0) begin
                errors++;
                $display("FAIL unexpected_event inst=%0d cyc=%0d kind=%0d required=none", w, cyc, kind);
            end else begin
                e = exp_q[w].pop_front();
                if (e.cyc != cyc || e.kind != kind) begin
                    errors++;
                    $display("FAIL event inst=%0d actual cyc=%0d kind=%0d required cyc=%0d kind=%0d",
                             w, cyc, kind, e.cyc, e.kind);
                end
                act = (kind == K_C2) ? prev_ar[w] : (kind == K_WR) ? int'(aw_s[w]) : int'(busy_s[w]);
                checks++;
                if (act != e.val) begin
                    errors++;
                    $display("FAIL event_value inst=%0d cyc=%0d kind=%0d actual=%0d required=%0d",
                             w, cyc, kind, act, e.val);
                end
                exp_c3 = (kind == K_C2) ? 1 : (kind == K_WR) ? 2 : 0;
                checks++;
                if (int'(c3_s[w]) != exp_c3) begin
                    errors++;
                    $display("FAIL c3 inst=%0d cyc=%0d kind=%0d actual=%0d required=%0d",
                             w, cyc, kind, c3_s[w], exp_c3);
                end
            end
        end
        prev_ar[w] = int'(ar_s[w]);
    endtask

    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) mon(w);
    end

    // mode 0: no stalls, 1: three stall cycles at address 2, 2: random stalls
    task automatic run(input int w, input int mode, input bit pokes, input bit do_reset);
        bit ir[256];
        int t0, done_c, r_cyc, k;
        for (int j = 0; j < 256; j++) begin
            case (mode)
                0:       ir[j] = 1'b1;
                1:       ir[j] = !(j >= 3 && j <= 5);
                default: ir[j] = (j > 100) || ($urandom_range(0, 3) != 0);
            endcase
        end
        t0 = cyc;
        model(w, t0, ir, done_c);
        r_cyc = do_reset ? done_c - UY[w] : -1;
        rst[w] = 1'b0;
        start_s[w] = 1'b1;
        ir_s[w] = 1'($urandom_range(0, 1));
        forever begin
            @(posedge clk); #1;
            k = cyc - t0;
            start_s[w] = pokes && (k == 4 || cyc == done_c - 1);
            ir_s[w] = ir[k - 1];
            if (cyc == r_cyc) begin
                rst[w] = 1'b1;
                for (int i = exp_q[w].size() - 1; i >= 0; i--)
                    if (exp_q[w][i].cyc > r_cyc) exp_q[w].delete(i);
            end
            if (do_reset && cyc == r_cyc + 1) begin
                rst[w] = 1'b0;
                @(negedge clk);
                checks++;
                if ({dvo_s[w], busy_s[w], done_s[w]} != 3'b000) begin
                    errors++;
                    $display("FAIL reset_abort inst=%0d dvo/busy/done actual=%b required=000", w,
                             {dvo_s[w], busy_s[w], done_s[w]});
                end
                break;
            end
            if (!do_reset && cyc == done_c + 1) begin
                @(negedge clk);
                checks++;
                if (busy_s[w] !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_fall inst=%0d cyc=%0d actual=%b required=0", w, cyc, busy_s[w]);
                end
                break;
            end
        end
        $display("run inst=%0d mode=%0d pokes=%0d reset=%0d start_cyc=%0d done_cyc=%0d", w, mode,
                 pokes, do_reset, t0, done_c);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst[w] = 1'b1; start_s[w] = 1'b1; ir_s[w] = 1'b1; prev_ar[w] = 0;
        end
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                checks++;
                if ({c1_s[w], c2_s[w], c3_s[w], ar_s[w], aw_s[w], dvo_s[w], busy_s[w], done_s[w]} != '0) begin
                    errors++;
                    $display("FAIL reset_state inst=%0d actual c1=%b c2=%b c3=%b ar=%0d aw=%0d dvo=%b busy=%b done=%b required all 0",
                             w, c1_s[w], c2_s[w], c3_s[w], ar_s[w], aw_s[w], dvo_s[w], busy_s[w], done_s[w]);
                end
            end
        end
        @(posedge clk); #1;
        rst[1] = 1'b0; start_s[1] = 1'b0;
        run(0, 0, 1'b0, 1'b0);
        run(0, 1, 1'b0, 1'b0);
        run(0, 0, 1'b1, 1'b0);
        run(0, 0, 1'b0, 1'b1);
        run(0, 0, 1'b0, 1'b0);
        repeat (4) run(0, 2, 1'($urandom_range(0, 1)), 1'b0);
        start_s[0] = 1'b0;
        run(1, 0, 1'b0, 1'b0);
        repeat (3) run(1, 2, 1'($urandom_range(0, 1)), 1'b0);
        run(1, 2, 1'b0, 1'b1);
        start_s[1] = 1'b0;
        repeat (4) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (exp_q[w].size() != 0) begin
                errors++;
                $display("FAIL leftover_events inst=%0d actual=%0d required=0", w, exp_q[w].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
